// File: rtl/game_if.sv
// Signal bundle between the round sequencer and the renderer/physics/button side.
// "master" is the sequencer's view, "slave" is the view of the blocks around it.
interface game_if;
    logic        btn_raw;
    logic        pipe_passed;
    logic        pipe_collision;
    logic        ground_hit;
    logic        game_enable;
    logic        round_reset;
    logic        flap;
    logic [11:0] score_bcd;
    logic [11:0] high_bcd;
    logic [2:0]  state;

    modport master (
        input  btn_raw, pipe_passed, pipe_collision, ground_hit,
        output game_enable, round_reset, flap, score_bcd, high_bcd, state
    );

    modport slave (
        output btn_raw, pipe_passed, pipe_collision, ground_hit,
        input  game_enable, round_reset, flap, score_bcd, high_bcd, state
    );
endinterface

// File: rtl/game_controller.sv
// Flappy Bird round sequencer: flap button debounce, BCD score/high score,
// and the IDLE -> START -> PLAYING -> DYING -> OVER round flow.
module game_controller #(
    parameter int DEBOUNCE_CYCLES   = 250_000,
    parameter int DEATH_HOLD_CYCLES = 50_000_000
) (
    input  logic   clk,
    input  logic   reset,
    game_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_PLAYING = 3'd2,
        S_DYING   = 3'd3,
        S_OVER    = 3'd4
    } state_e;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (DEATH_HOLD_CYCLES > 1) ? $clog2(DEATH_HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(DEATH_HOLD_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q;
    logic [DW-1:0] deb_cnt_q;
    logic          btn_pulse_q;

    state_e        state_q, state_d;
    logic [11:0]   score_q, score_d;
    logic [11:0]   high_q, high_d;
    logic [HW-1:0] hold_q, hold_d;

    // Saturating 3-digit BCD increment.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 12'h999) begin
            for (int i = 0; i < 3; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            btn_pulse_q <= 1'b0;
        end else begin
            sync1_q     <= bus.btn_raw;
            sync2_q     <= sync1_q;
            btn_pulse_q <= 1'b0;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DB_LAST) begin
                // Accept the new level; only a press (rising level) yields a pulse.
                deb_q       <= sync2_q;
                deb_cnt_q   <= '0;
                btn_pulse_q <= sync2_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            score_q <= '0;
            high_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            high_q  <= high_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (btn_pulse_q) state_d = S_START;
            end
            S_START: begin
                score_d = '0;
                state_d = S_PLAYING;
            end
            S_PLAYING: begin
                // A death in the same clock as a pipe clear forfeits that point.
                if (bus.pipe_collision || bus.ground_hit) begin
                    state_d = S_DYING;
                    hold_d  = '0;
                end else if (bus.pipe_passed) begin
                    score_d = bcd_inc(score_q);
                end
            end
            S_DYING: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_OVER;
                    if (score_q > high_q) high_d = score_q;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_OVER: begin
                if (btn_pulse_q) state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.game_enable = (state_q == S_PLAYING);
    assign bus.round_reset = (state_q == S_START);
    assign bus.flap        = btn_pulse_q && (state_q == S_PLAYING);
    assign bus.score_bcd   = score_q;
    assign bus.high_bcd    = high_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with short debounce/death-hold parameters.
module tb_game_controller;

    localparam int DEB  = 8;
    localparam int HOLD = 20;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    int   rr_cnt;
    int   flap_cnt;
    int   base;

    game_if bus ();

    game_controller #(
        .DEBOUNCE_CYCLES  (DEB),
        .DEATH_HOLD_CYCLES(HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rr_cnt   = 0;
        flap_cnt = 0;
    end

    always @(negedge clk) begin
        if (bus.round_reset === 1'b1) rr_cnt++;
        if (bus.flap === 1'b1) flap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic press();
        bus.btn_raw = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        bus.btn_raw = 1'b0;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic pipes(input int n);
        repeat (n) begin
            bus.pipe_passed = 1'b1;
            @(negedge clk);
            bus.pipe_passed = 1'b0;
            @(negedge clk);
        end
    endtask

    // Kill the bird (collision or ground), then wait out the frozen frame.
    task automatic die(input bit use_ground, input string tag);
        if (use_ground) bus.ground_hit = 1'b1;
        else            bus.pipe_collision = 1'b1;
        @(negedge clk);
        bus.ground_hit     = 1'b0;
        bus.pipe_collision = 1'b0;
        check({tag, "_dying"}, 32'(bus.state), 32'd3);
        repeat (HOLD - 2) @(negedge clk);
        check({tag, "_still_dying"}, 32'(bus.state), 32'd3);
        repeat (3) @(negedge clk);
        check({tag, "_over"}, 32'(bus.state), 32'd4);
    endtask

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        reset              = 1'b1;
        bus.btn_raw        = 1'b0;
        bus.pipe_passed    = 1'b0;
        bus.pipe_collision = 1'b0;
        bus.ground_hit     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_score", 32'(bus.score_bcd), 32'h000);
        check("rst_high", 32'(bus.high_bcd), 32'h000);
        check("rst_enable", 32'(bus.game_enable), 32'd0);
        check("rst_round_reset", 32'(bus.round_reset), 32'd0);
        check("rst_flap", 32'(bus.flap), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: short glitch must not be accepted
        bus.btn_raw = 1'b1;
        repeat (DEB / 2) @(negedge clk);
        bus.btn_raw = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        check("glitch_state", 32'(bus.state), 32'd0);
        check("glitch_no_rr", 32'(rr_cnt), 32'd0);

        // 2: start and flap
        press();
        check("start_rr_once", 32'(rr_cnt), 32'd1);
        check("start_state", 32'(bus.state), 32'd2);
        check("start_enable", 32'(bus.game_enable), 32'd1);
        check("start_score", 32'(bus.score_bcd), 32'h000);
        base = flap_cnt;
        press();
        check("flap_once", 32'(flap_cnt - base), 32'd1);

        // 3: BCD carries and saturation
        pipes(3);
        check("score_003", 32'(bus.score_bcd), 32'h003);
        pipes(6);
        check("score_009", 32'(bus.score_bcd), 32'h009);
        pipes(1);
        check("score_010", 32'(bus.score_bcd), 32'h010);
        pipes(89);
        check("score_099", 32'(bus.score_bcd), 32'h099);
        pipes(1);
        check("score_100", 32'(bus.score_bcd), 32'h100);
        pipes(899);
        check("score_999", 32'(bus.score_bcd), 32'h999);
        pipes(1);
        check("score_sat", 32'(bus.score_bcd), 32'h999);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst2_high", 32'(bus.high_bcd), 32'h000);

        // 4: simultaneous pipe clear and collision at 005
        press();
        pipes(5);
        bus.pipe_passed    = 1'b1;
        bus.pipe_collision = 1'b1;
        @(negedge clk);
        bus.pipe_passed    = 1'b0;
        bus.pipe_collision = 1'b0;
        check("tie_score", 32'(bus.score_bcd), 32'h005);
        check("tie_state", 32'(bus.state), 32'd3);
        check("tie_enable", 32'(bus.game_enable), 32'd0);
        pipes(1);
        check("dying_ignores_pipe", 32'(bus.score_bcd), 32'h005);
        repeat (HOLD) @(negedge clk);
        check("tie_over", 32'(bus.state), 32'd4);
        check("tie_high", 32'(bus.high_bcd), 32'h005);

        // 5: high score keeps the best round
        base = rr_cnt;
        press();
        check("restart_rr", 32'(rr_cnt - base), 32'd1);
        check("restart_score", 32'(bus.score_bcd), 32'h000);
        pipes(7);
        die(1'b1, "r7");
        check("r7_high", 32'(bus.high_bcd), 32'h007);
        press();
        pipes(4);
        die(1'b0, "r4");
        check("r4_score", 32'(bus.score_bcd), 32'h004);
        check("r4_high", 32'(bus.high_bcd), 32'h007);
        press();
        check("r0_score", 32'(bus.score_bcd), 32'h000);
        check("r0_state", 32'(bus.state), 32'd2);

        // 6: asynchronous reset mid-round
        pipes(20);
        die(1'b0, "r20");
        check("r20_high", 32'(bus.high_bcd), 32'h020);
        press();
        pipes(12);
        check("pre_rst_score", 32'(bus.score_bcd), 32'h012);
        #2 reset = 1'b1;
        #1;
        check("arst_state", 32'(bus.state), 32'd0);
        check("arst_score", 32'(bus.score_bcd), 32'h000);
        check("arst_high", 32'(bus.high_bcd), 32'h000);
        check("arst_enable", 32'(bus.game_enable), 32'd0);
        check("arst_round_reset", 32'(bus.round_reset), 32'd0);
        check("arst_flap", 32'(bus.flap), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
